// File: rtl/serial_sub32.sv
// serial_sub32: byte-serial 32-bit subtractor computing ra - rb - bin.
// Operands are captured when a request is accepted. One 8-bit slice is
// resolved per clock, least-significant byte first, with the borrow
// carried between slices in a register. The result, borrow-out and
// signed overflow are registered and presented with a one-cycle done pulse.
module serial_sub32 (
  input  logic        TClk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ra,
  input  logic [31:0] rb,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        bout,
  output logic        ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One slice: {borrow_out, d} = a - b - bi, formed as a + ~b + ~bi.
  // The carry out of that sum is the inverse of the borrow.
  function automatic logic [8:0] sub_slice(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic       bi);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, ~b} + {8'd0, ~bi};
    return {~sum[8], sum[7:0]};
  endfunction

  // Signed overflow of a - b, judged from the operand signs and the result sign.
  function automatic logic sub_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

  state_t      state_r, state_s;
  logic [31:0] a_r, a_s;
  logic [31:0] b_r, b_s;
  logic [1:0]  idx_r, idx_s;
  logic        borrow_r, borrow_s;
  logic [31:0] acc_r, acc_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [31:0] diff_r, diff_s;
  logic        bout_r, bout_s;
  logic        ovf_r, ovf_s;
  logic [8:0]  slice_s;

  // State and datapath registers, with synchronous reset taking priority.
  always_ff @(posedge TClk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      idx_r    <= 2'd0;
      borrow_r <= 1'b0;
      acc_r    <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= 32'd0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      idx_r    <= idx_s;
      borrow_r <= borrow_s;
      acc_r    <= acc_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      diff_r   <= diff_s;
      bout_r   <= bout_s;
      ovf_r    <= ovf_s;
    end
  end

  // Next-state and next-value logic: hold everything unless the state acts on it.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    idx_s    = idx_r;
    borrow_s = borrow_r;
    acc_s    = acc_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    diff_s   = diff_r;
    bout_s   = bout_r;
    ovf_s    = ovf_r;
    slice_s  = sub_slice(a_r[{idx_r, 3'b000} +: 8], b_r[{idx_r, 3'b000} +: 8], borrow_r);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          a_s      = ra;
          b_s      = rb;
          idx_s    = 2'd0;
          borrow_s = bin;
          busy_s   = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_s[{idx_r, 3'b000} +: 8] = slice_s[7:0];
        borrow_s = slice_s[8];
        idx_s    = idx_r + 2'd1;
        if (idx_r == 2'd3) begin
          diff_s  = acc_s;
          bout_s  = slice_s[8];
          ovf_s   = sub_ovf(a_r[31], b_r[31], acc_s[31]);
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        idx_s   = 2'd0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        idx_s   = 2'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;

endmodule
